// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
// Autonomous fetch/issue controller for the 16-bit multicycle processor.
// Walks a program counter over instruction memory, waits out the memory read
// latency, hands each fetched word to the processor on DIN together with a
// one-cycle Run pulse, then waits for Done before advancing. Supports
// free-run, single-step, stop at an instruction boundary, and a halt word.
//
// Ports:
//   Clock       system clock (shared with proc and inst_mem)
//   Resetn      asynchronous active-low reset
//   Start       level, starts from address 0 when idle or halted
//   Stop        level, return to idle at the next instruction boundary
//   StepMode    1 = pause after every completed instruction
//   Step        one-cycle pulse that releases a pause
//   MemData     instruction word from inst_mem
//   Done        processor completion strobe
//   MemAddr     program counter, drives the inst_mem address
//   DIN         instruction word presented to the processor
//   Run         issue pulse to the processor
//   Busy        high in FETCH, ISSUE and EXEC
//   Halted      high in HALTED
//   Fault       watchdog fault flag
//   InstrCount  completed instructions, saturating at 16'hFFFF
//
// Build option: define PROG_SEQ_WATCHDOG_EN to add an EXEC watchdog that
// moves to a reset-only FAULT state when Done does not arrive within
// WD_CYCLES cycles. Without it Fault is tied low and EXEC waits forever.
// -----------------------------------------------------------------------------
module prog_sequencer #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned MEM_LAT   = 1,
    parameter logic [15:0] HALT_WORD = 16'hE000,
    parameter int unsigned WD_CYCLES = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic              StepMode,
    input  logic              Step,
    input  logic [15:0]       MemData,
    input  logic              Done,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [15:0]       DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Halted,
    output logic              Fault,
    output logic [15:0]       InstrCount
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
            $error("prog_sequencer: MEM_LAT must lie in 1..7");
        end
        if (WD_CYCLES < 1 || WD_CYCLES > 15) begin : g_bad_wd_cycles
            $error("prog_sequencer: WD_CYCLES must lie in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_EXEC   = 3'd3,
        S_PAUSE  = 3'd4,
        S_HALTED = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // Last FETCH cycle: memory data is sampled on the edge that ends it.
    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       din_q;
    logic [15:0]       count_q;
    logic [2:0]        lat_q;
    logic              run_q;
    logic              busy_q;
    logic              halted_q;

`ifdef PROG_SEQ_WATCHDOG_EN
    localparam logic [3:0] WD_LAST = 4'(WD_CYCLES - 1);
    logic [3:0]        wd_q;
    logic              fault_q;
`endif

    // Instruction counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Sequencer FSM: state, program counter, counters and all registered outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            din_q    <= 16'h0000;
            count_q  <= 16'h0000;
            lat_q    <= 3'd0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
`ifdef PROG_SEQ_WATCHDOG_EN
            wd_q     <= 4'd0;
            fault_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    // Stop wins over Start so a held Stop keeps us parked.
                    if (Start && !Stop) begin
                        state_q  <= S_FETCH;
                        pc_q     <= '0;
                        count_q  <= 16'h0000;
                        lat_q    <= 3'd0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end else begin
                        state_q  <= state_q;
                    end
                end

                S_FETCH: begin
                    if (Stop) begin
                        // Abandon the fetch; PC still points at it.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (lat_q == LAT_LAST) begin
                        // MemData is valid on this edge. A halt word is
                        // captured but never accompanied by Run.
                        state_q <= S_ISSUE;
                        din_q   <= MemData;
                        run_q   <= (MemData != HALT_WORD);
                    end else begin
                        lat_q   <= lat_q + 3'd1;
                    end
                end

                S_ISSUE: begin
                    // Stop is deliberately ignored here: the issue commits.
                    run_q <= 1'b0;
                    if (din_q == HALT_WORD) begin
                        state_q  <= S_HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= S_EXEC;
`ifdef PROG_SEQ_WATCHDOG_EN
                        wd_q     <= 4'd0;
`endif
                    end
                end

                S_EXEC: begin
                    if (Done) begin
                        pc_q    <= pc_q + ADDR_W'(1);
                        count_q <= sat_inc16(count_q);
                        if (Stop) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else if (StepMode) begin
                            state_q <= S_PAUSE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_FETCH;
                            lat_q   <= 3'd0;
                        end
                    end else begin
`ifdef PROG_SEQ_WATCHDOG_EN
                        if (wd_q == WD_LAST) begin
                            state_q <= S_FAULT;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                        end else begin
                            wd_q    <= wd_q + 4'd1;
                        end
`else
                        state_q <= S_EXEC;
`endif
                    end
                end

                S_PAUSE: begin
                    // Only a Step pulse releases a pause; clearing StepMode does not.
                    if (Stop) begin
                        state_q <= S_IDLE;
                    end else if (Step) begin
                        state_q <= S_FETCH;
                        lat_q   <= 3'd0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_PAUSE;
                    end
                end

                S_FAULT: begin
                    // Sticky until reset; PC and InstrCount stay frozen.
                    state_q <= S_FAULT;
                end

                default: begin
                    state_q  <= S_IDLE;
                    run_q    <= 1'b0;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign MemAddr    = pc_q;
    assign DIN        = din_q;
    assign Run        = run_q;
    assign Busy       = busy_q;
    assign Halted     = halted_q;
    assign InstrCount = count_q;

`ifdef PROG_SEQ_WATCHDOG_EN
    assign Fault      = fault_q;
`else
    assign Fault      = 1'b0;
`endif

endmodule
